vga_pattern_ctrl: RTL and testbench

VGA_PATTERN_CTRL -- requirements
Module: vga_pattern_ctrl

---
 rtl/vga_pattern_ctrl_pkg.sv | 24 ++
 rtl/vga_pattern_ctrl_db_fsm.sv | 43 ++++
 rtl/vga_pattern_ctrl.sv | 106 ++++++++++
 tb/tb_vga_pattern_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_ctrl_pkg.sv
// Shared definitions for the VGA test-pattern controller: sequencer states,
// pattern index constants and the debounce counter width.
package vga_pattern_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam logic [2:0] PAT_BARS     = 3'd0;
    localparam logic [2:0] PAT_INV_BARS = 3'd1;
    localparam logic [2:0] PAT_CHECKER  = 3'd2;
    localparam logic [2:0] PAT_RAMP     = 3'd3;
    localparam logic [2:0] PAT_SOLID    = 3'd4;

    localparam int DB_W = 20;

    // Next pattern index, wrapping after the last configured pattern.
    function automatic logic [2:0] next_pat(input logic [2:0] cur, input int num);
        return (int'(cur) == num - 1) ? PAT_BARS : cur + 3'd1;
    endfunction

endpackage

// File: rtl/vga_pattern_ctrl_db_fsm.sv
// Push-button conditioner: two-flop synchroniser followed by a stable-time
// debouncer; emits a single-clk pulse on each debounced rising edge.
module db_fsm
    import vga_pattern_ctrl_pkg::*;
#(
    parameter logic [DB_W-1:0] DB_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic rise
);

    logic            sync1;
    logic            sync2;
    logic            stable;
    logic [DB_W-1:0] cnt;

    // Synchronise, then accept a new level only after it has held DB_CYCLES clks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DB_CYCLES - 1'b1) begin
                cnt    <= '0;
                stable <= sync2;
                rise   <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_ctrl.sv
// VGA test-pattern sequencer: frame-start detection, button/auto advance,
// one blanked frame per pattern change, and colour-bar scrolling.
// Optional feature macro: VGA_PATTERN_AUTO_EN (timed auto-advance).
module vga_pattern_ctrl
    import vga_pattern_ctrl_pkg::*;
#(
    parameter int              NUM_PAT        = 5,
    parameter int              FRAMES_PER_PAT = 120,
    parameter int              SHIFT_FRAMES   = 8,
    parameter logic [DB_W-1:0] DB_CYCLES      = 20'd1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       p_tick,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       btn_next,
    input  logic       scroll_en,
    output logic [2:0] pat_sel,
    output logic [2:0] bar_shift,
    output logic       blank,
    output logic       frame_tick
);

    state_t     state;
    logic [9:0] frame_cnt;
    logic [7:0] shift_cnt;
    logic       btn_rise;
    logic       adv_req;

    db_fsm #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_next),
        .rise    (btn_rise)
    );

`ifdef VGA_PATTERN_AUTO_EN
    // A timed request and a button pulse in the same clk merge into one.
    logic auto_req;
    assign auto_req = frame_tick && (state == ST_RUN) &&
                      (frame_cnt == 10'(FRAMES_PER_PAT - 1));
    assign adv_req  = btn_rise | auto_req;
`else
    assign adv_req  = btn_rise;
`endif

    // Registered frame-start pulse: first pixel of the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_tick <= 1'b0;
        else          frame_tick <= p_tick && (pix_x == 10'd0) && (pix_y == 10'd0);
    end

    // Sequencer: pattern changes land only on frame boundaries, followed by one black frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            pat_sel   <= PAT_BARS;
            blank     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (frame_tick)
                        frame_cnt <= (frame_cnt == 10'(FRAMES_PER_PAT - 1)) ? 10'd0
                                                                            : frame_cnt + 10'd1;
                    if (adv_req) state <= ST_PEND;
                end
                ST_PEND: begin
                    if (frame_tick) begin
                        state     <= ST_BLANK;
                        blank     <= 1'b1;
                        pat_sel   <= next_pat(pat_sel, NUM_PAT);
                        frame_cnt <= '0;
                    end
                end
                ST_BLANK: begin
                    if (frame_tick) begin
                        state <= ST_RUN;
                        blank <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    blank <= 1'b0;
                end
            endcase
        end
    end

    // Colour-bar rotation: steps every SHIFT_FRAMES frames while enabled, frozen in blank frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_cnt <= '0;
            bar_shift <= '0;
        end else if (frame_tick && scroll_en && (state != ST_BLANK)) begin
            if (shift_cnt == 8'(SHIFT_FRAMES - 1)) begin
                shift_cnt <= '0;
                bar_shift <= bar_shift + 3'd1;
            end else begin
                shift_cnt <= shift_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Self-checking bench for vga_pattern_ctrl. Each frame is 128 clks (16x4
// pixels, p_tick every other clk); a frame-level model predicts pattern,
// blank and bar_shift from the frame boundaries and button presses.
// Honours VGA_PATTERN_AUTO_EN when the design is built with it.
module tb_vga_pattern_ctrl;

    localparam int NP  = 5;
    localparam int FPP = 4;
    localparam int SF  = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       p_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       btn_next;
    logic       scroll_en;
    logic [2:0] pat_sel;
    logic [2:0] bar_shift;
    logic       blank;
    logic       frame_tick;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    int m_pat, m_bs, m_sc, m_fc;
    bit m_pend, m_blank;
    bit held = 1'b0;

    vga_pattern_ctrl #(
        .NUM_PAT        (NP),
        .FRAMES_PER_PAT (FPP),
        .SHIFT_FRAMES   (SF),
        .DB_CYCLES      (20'd20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .p_tick     (p_tick),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .btn_next   (btn_next),
        .scroll_en  (scroll_en),
        .pat_sel    (pat_sel),
        .bar_shift  (bar_shift),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = 0; m_bs = 0; m_sc = 0; m_fc = 0; m_pend = 0; m_blank = 0;
    endtask

    // What happens at a frame boundary, from the behavioural rules.
    task automatic model_tick();
        if (m_blank) begin
            m_blank = 0;
        end else begin
            if (scroll_en) begin
                m_sc++;
                if (m_sc == SF) begin m_sc = 0; m_bs = (m_bs + 1) % 8; end
            end
            if (m_pend) begin
                m_pend = 0; m_blank = 1; m_pat = (m_pat + 1) % NP; m_fc = 0;
            end else begin
`ifdef VGA_PATTERN_AUTO_EN
                m_fc++;
                if (m_fc == FPP) m_pend = 1;
`endif
            end
        end
    endtask

    task automatic model_press();
        if (!m_pend && !m_blank) m_pend = 1;
    endtask

    // mode: 0 idle, 1 clean press, 2 bouncing press, 3 two presses, 5 hold high
    task automatic run_frame(input int mode, input int rst_at, input bit scr);
        int ft_cnt, ft_pos, blank_bad, pat_bad, idx, n, tlast;
        int be[10];
        bit press;
        ft_cnt = 0; ft_pos = -1; blank_bad = 0; pat_bad = 0; tlast = 0;
        for (int k = 0; k < 10; k++) be[k] = 0;
        if (mode == 2) begin
            be[0] = 4 + $urandom_range(0, 3);
            for (int k = 1; k < 10; k++) be[k] = be[k-1] + $urandom_range(1, 4);
            tlast = be[9] + 2;
        end
        press = (mode == 1) || (mode == 2) || (mode == 3) || (mode == 5 && !held);
        for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            idx    = c / 2;
            p_tick = (c % 2 == 0);
            pix_x  = 10'(idx % 16);
            pix_y  = 10'(idx / 16);
            case (mode)
                1: btn_next = (c >= 4 && c < 40);
                2: begin
                    n = 0;
                    for (int k = 0; k < 10; k++) if (be[k] <= c) n++;
                    btn_next = (c < tlast) ? (n % 2 == 1) : (c < 90);
                end
                3: btn_next = (c >= 4 && c < 30) || (c >= 60 && c < 90);
                5: btn_next = (c >= 4) || held;
                default: btn_next = 1'b0;
            endcase
            if (c == 64) scroll_en = scr;
            if (c == rst_at) reset_n = 1'b0;
            if (c == rst_at + 3) reset_n = 1'b1;
            @(posedge clk); #1;
            if (frame_tick) begin ft_cnt++; ft_pos = c; end
            if (c == 0) model_tick();
            if (c == 1 && press) model_press();
            if (c == rst_at) begin
                model_reset();
                chk("rst_pat_sel", pat_sel, 0);
                chk("rst_blank", blank, 0);
                chk("rst_bar_shift", bar_shift, 0);
                chk("rst_frame_tick", frame_tick, 0);
            end
            if (c >= 1) begin
                if (blank !== m_blank) blank_bad++;
                if (pat_sel !== 3'(m_pat)) pat_bad++;
            end
            if (c == 100) begin
                chk("mid_pat_sel", pat_sel, m_pat);
                chk("mid_blank", blank, m_blank);
                chk("mid_bar_shift", bar_shift, m_bs);
            end
        end
        held = (mode == 5);
        chk("frame_tick_count", ft_cnt, 1);
        chk("frame_tick_at_origin", ft_pos, 0);
        chk("blank_steady_cycles_bad", blank_bad, 0);
        chk("pat_sel_steady_cycles_bad", pat_bad, 0);
    endtask

    initial begin
        int wraps, prev;
        reset_n = 1'b0; p_tick = 1'b0; pix_x = '0; pix_y = '0;
        btn_next = 1'b0; scroll_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("por_pat_sel", pat_sel, 0);
        chk("por_blank", blank, 0);
        chk("por_bar_shift", bar_shift, 0);
        chk("por_frame_tick", frame_tick, 0);
        @(negedge clk) reset_n = 1'b1;

        // idle frames
        repeat (3) run_frame(0, -10, 0);

        // single clean press, then blank frame, then run
        run_frame(1, -10, 0);
        run_frame(0, -10, 0);
        run_frame(0, -10, 0);
`ifndef VGA_PATTERN_AUTO_EN
        chk("press_pat_sel", pat_sel, 1);
`endif

        // five separated presses from a fresh start; first one doubled inside PEND
        run_frame(0, 100, 0);
        for (int k = 0; k < 5; k++) begin
            run_frame((k == 0) ? 3 : 1, -10, 0);
            run_frame(0, -10, 0);
            run_frame(0, -10, 0);
`ifndef VGA_PATTERN_AUTO_EN
            chk("seq_pat_sel", pat_sel, (k + 1) % NP);
`endif
        end

        // bouncing press -> one advance; press during blank frame ignored
        run_frame(2, -10, 0);
        run_frame(1, -10, 0);
        run_frame(0, -10, 0);

        // holding the button across frames does not repeat
        run_frame(5, -10, 0);
        run_frame(5, -10, 0);
        run_frame(5, -10, 0);
        run_frame(0, -10, 0);
        run_frame(0, -10, 0);

        // reset during PEND, then reset during BLANK
        run_frame(1, 100, 0);
        run_frame(0, -10, 0);
        run_frame(1, -10, 0);
        run_frame(0, 100, 0);
        run_frame(0, -10, 0);
        chk("post_rst_pat_sel", pat_sel, m_pat);

        // scrolling over 64 frames
        run_frame(0, 100, 1);
        wraps = 0;
        prev  = bar_shift;
        for (int f = 0; f < 64; f++) begin
            run_frame(0, -10, 1);
            if (prev == 7 && bar_shift == 3'd0) wraps++;
            prev = bar_shift;
        end
`ifndef VGA_PATTERN_AUTO_EN
        chk("scroll_wraps", wraps, 1);
        chk("scroll_final", bar_shift, 0);
`endif

        // scroll disabled holds the offset
        run_frame(0, -10, 0);
        prev = bar_shift;
        repeat (10) run_frame(0, -10, 0);
        chk("scroll_hold", bar_shift, prev);

`ifdef VGA_PATTERN_AUTO_EN
        // auto advance after reset in BLANK
        run_frame(0, 100, 0);
        repeat (5) run_frame(0, -10, 0);
        chk("auto_pat_sel", pat_sel, 1);
        chk("auto_blank", blank, 1);
`endif

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            int r;
            r = $urandom_range(0, 5);
            run_frame((r == 4 || r == 5) ? 0 : r, ($urandom_range(0, 15) == 0) ? 110 : -10,
                      1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
